// File: rtl/io_fifo_pkg.sv
// Shared definitions for the watermark FIFO family: level-width helper,
// default peripheral depths and a status record for register-file packing.
package io_fifo_pkg;

  localparam int IO_FIFO_UART_RX_DEPTH = 16;
  localparam int IO_FIFO_UART_TX_DEPTH = 16;

  // Width needed to hold a fill level of 0..depth inclusive.
  function automatic int io_fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
    logic trigger;
    logic almost_empty;
    logic timeout;
  } io_fifo_status_t;

endpackage

// File: rtl/io_fifo_ptr.sv
// Modulo-DEPTH pointer.
// DEPTH need not be a power of two, so the wrap is an explicit compare
// against DEPTH-1 rather than a natural binary rollover.
module io_fifo_ptr
  import io_fifo_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int PTR_W = io_fifo_lvl_w(DEPTH) - 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next pointer: flush to 0, otherwise advance and wrap after DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
      else                            ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/io_watermark_fifo.sv
// First-word fall-through FIFO with arbitrary depth, trigger / almost-empty
// watermarks and sticky overflow/underflow flags.
// Optional inactivity timeout is compiled in with IO_FIFO_TIMEOUT_EN;
// without it timeout_o is tied low and timeout_cycles_i is ignored.
module io_watermark_fifo
  import io_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int BUFFER_DEPTH     = IO_FIFO_UART_RX_DEPTH,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
  parameter int TO_WIDTH         = 10
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      err_clr_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  input  logic [LOG_BUFFER_DEPTH:0] trig_level_i,
  input  logic [LOG_BUFFER_DEPTH:0] ae_thresh_i,
  output logic [LOG_BUFFER_DEPTH:0] elements_o,
  output logic                      trigger_o,
  output logic                      almost_empty_o,
  output logic                      ovf_o,
  output logic                      udf_o,
  input  logic [TO_WIDTH-1:0]       timeout_cycles_i,
  output logic                      timeout_o
);

  localparam int LVL_W = LOG_BUFFER_DEPTH + 1;

  logic [LVL_W-1:0]            elements_q, elements_d;
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
  logic                        ovf_q, ovf_d, udf_q, udf_d;
  logic                        full, push, pop;

  assign full    = (elements_q == LVL_W'(BUFFER_DEPTH));
  assign valid_o = (elements_q != '0);
  assign ready_o = !full;
  // A flush swallows any transfer in the same cycle.
  assign push    = valid_i && !full && !clr_i;
  assign pop     = ready_i && valid_o && !clr_i;

  io_fifo_ptr #(.DEPTH(BUFFER_DEPTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clr_i),
    .inc_i  (push),
    .ptr_o  (wr_ptr)
  );

  io_fifo_ptr #(.DEPTH(BUFFER_DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clr_i),
    .inc_i  (pop),
    .ptr_o  (rd_ptr)
  );

  // Fill level and sticky error flags; a new error beats err_clr_i.
  always_comb begin
    elements_d = elements_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clr_i) begin
      elements_d = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      if (push && !pop)      elements_d = elements_q + LVL_W'(1);
      else if (pop && !push) elements_d = elements_q - LVL_W'(1);
      if (valid_i && full)        ovf_d = 1'b1;
      else if (err_clr_i)         ovf_d = 1'b0;
      if (ready_i && !valid_o)    udf_d = 1'b1;
      else if (err_clr_i)         udf_d = 1'b0;
    end
  end

  // Level and flag registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      elements_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      elements_q <= elements_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage; deliberately not touched by clr_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign data_o         = mem_q[rd_ptr];
  assign elements_o     = elements_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;
  assign trigger_o      = (trig_level_i != '0) && (elements_q >= trig_level_i);
  assign almost_empty_o = (elements_q <= ae_thresh_i);

`ifdef IO_FIFO_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q;

  // Idle counter: restarts on any traffic or when empty, saturates at all-ones.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
    end else if (clr_i || push || pop || !valid_o) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
    end
  end

  assign timeout_o = (timeout_cycles_i != '0) && valid_o && (to_cnt_q >= timeout_cycles_i);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^timeout_cycles_i;
  assign timeout_o             = 1'b0;
`endif

endmodule

// File: tb/tb_io_watermark_fifo.sv
// Scoreboard bench for io_watermark_fifo at DEPTH=5, WIDTH=8.
module tb_io_watermark_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int LOGD = $clog2(DEPTH);
  localparam int TOW = 10;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            clr_i, err_clr_i, valid_i, ready_i;
  logic [DW-1:0]   data_i;
  logic            ready_o, valid_o;
  logic [DW-1:0]   data_o;
  logic [LOGD:0]   trig_level_i, ae_thresh_i, elements_o;
  logic            trigger_o, almost_empty_o, ovf_o, udf_o, timeout_o;
  logic [TOW-1:0]  timeout_cycles_i;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [DW-1:0]   sb_q [$];

  always #5 clk_i = ~clk_i;

  io_watermark_fifo #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .LOG_BUFFER_DEPTH(LOGD), .TO_WIDTH(TOW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .err_clr_i(err_clr_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .trig_level_i(trig_level_i), .ae_thresh_i(ae_thresh_i),
    .elements_o(elements_o), .trigger_o(trigger_o),
    .almost_empty_o(almost_empty_o), .ovf_o(ovf_o), .udf_o(udf_o),
    .timeout_cycles_i(timeout_cycles_i), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    valid_i = 1'b1;
    data_i  = d;
    sb_q.push_back(d);
    step();
    valid_i = 1'b0;
  endtask

  task automatic do_pop(input string tag);
    logic [DW-1:0] exp_d;
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    chk({tag, "_data"}, 32'(data_o), 32'(exp_d));
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; clr_i = 1'b0; err_clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; trig_level_i = '0; ae_thresh_i = '0; timeout_cycles_i = '0;
    step(); step();

    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_elems", 32'(elements_o), 32'd0);
    chk("rst_trig", 32'(trigger_o), 32'd0);
    chk("rst_ae", 32'(almost_empty_o), 32'd1);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_udf", 32'(udf_o), 32'd0);
    chk("rst_to", 32'(timeout_o), 32'd0);
    rstn_i = 1'b1;
    step();

    // Fill/drain three times so both pointers wrap 4 -> 0 repeatedly.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) do_push(8'(8'h11 + i + r * 8'h20));
      chk("fill_elems", 32'(elements_o), 32'(DEPTH));
      chk("fill_ready", 32'(ready_o), 32'd0);
      for (int i = 0; i < DEPTH; i++) do_pop("drain");
      chk("drain_elems", 32'(elements_o), 32'd0);
    end

    // Write while full with a simultaneous pop: pop happens, write dropped.
    for (int i = 0; i < DEPTH; i++) do_push(8'(8'h40 + i));
    chk("ovf_head", 32'(data_o), 32'(sb_q[0]));
    void'(sb_q.pop_front());
    valid_i = 1'b1; data_i = 8'hEE; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("ovf_elems", 32'(elements_o), 32'd4);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk("ovf_clr", 32'(ovf_o), 32'd0);
    for (int i = 0; i < 4; i++) do_pop("ovf_drain");
    chk("ovf_empty", 32'(elements_o), 32'd0);

    // Underflow, and set-wins-over-clear.
    ready_i = 1'b1; step(); ready_i = 1'b0;
    chk("udf_set", 32'(udf_o), 32'd1);
    chk("udf_elems", 32'(elements_o), 32'd0);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk("udf_clr", 32'(udf_o), 32'd0);
    ready_i = 1'b1; err_clr_i = 1'b1; step(); ready_i = 1'b0; err_clr_i = 1'b0;
    chk("udf_setwins", 32'(udf_o), 32'd1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;

    // Watermarks.
    trig_level_i = 4'd3; ae_thresh_i = 4'd1;
    do_push(8'hA1);
    chk("wm1_trig", 32'(trigger_o), 32'd0);
    chk("wm1_ae", 32'(almost_empty_o), 32'd1);
    do_push(8'hA2);
    chk("wm2_trig", 32'(trigger_o), 32'd0);
    chk("wm2_ae", 32'(almost_empty_o), 32'd0);
    do_push(8'hA3);
    chk("wm3_trig", 32'(trigger_o), 32'd1);
    trig_level_i = 4'd0; #1;
    chk("wm_trig_off", 32'(trigger_o), 32'd0);
    trig_level_i = 4'd6; ae_thresh_i = 4'd7; #1;
    chk("wm_trig_big", 32'(trigger_o), 32'd0);
    chk("wm_ae_big", 32'(almost_empty_o), 32'd1);
    trig_level_i = 4'd0; ae_thresh_i = 4'd0;
    for (int i = 0; i < 3; i++) do_pop("wm_drain");

    // Inactivity timeout.
    timeout_cycles_i = 10'd4;
`ifdef IO_FIFO_TIMEOUT_EN
    do_push(8'hB1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_early", 32'(timeout_o), 32'd0);
    end
    step();
    chk("to_fire", 32'(timeout_o), 32'd1);
    do_push(8'hB2);
    chk("to_push_drop", 32'(timeout_o), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("to_refire", 32'(timeout_o), 32'd1);
    do_pop("to_pop");
    chk("to_pop_drop", 32'(timeout_o), 32'd0);
    do_pop("to_pop2");
    for (int i = 0; i < 8; i++) step();
    chk("to_empty", 32'(timeout_o), 32'd0);
`else
    do_push(8'hB1);
    for (int i = 0; i < 6; i++) step();
    chk("to_disabled", 32'(timeout_o), 32'd0);
    do_pop("to_pop");
`endif
    timeout_cycles_i = '0;

    // Flush with errors set and a coincident push.
    ready_i = 1'b1; step(); ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_push(8'(8'h60 + i));
    valid_i = 1'b1; data_i = 8'hEE; step(); valid_i = 1'b0;
    do_pop("pre_clr");
    do_pop("pre_clr");
    chk("pre_clr_elems", 32'(elements_o), 32'd3);
    chk("pre_clr_ovf", 32'(ovf_o), 32'd1);
    chk("pre_clr_udf", 32'(udf_o), 32'd1);
    clr_i = 1'b1; valid_i = 1'b1; data_i = 8'h99;
    step();
    clr_i = 1'b0; valid_i = 1'b0;
    sb_q.delete();
    chk("clr_elems", 32'(elements_o), 32'd0);
    chk("clr_valid", 32'(valid_o), 32'd0);
    chk("clr_ovf", 32'(ovf_o), 32'd0);
    chk("clr_udf", 32'(udf_o), 32'd0);
    do_push(8'hC5);
    do_pop("post_clr");

    // Asynchronous reset mid-stream.
    do_push(8'hD1);
    do_push(8'hD2);
    trig_level_i = 4'd1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #3;
    rstn_i = 1'b0;
    #1;
    ready_i = 1'b0;
    sb_q.delete();
    chk("arst_elems", 32'(elements_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_trig", 32'(trigger_o), 32'd0);
    chk("arst_ae", 32'(almost_empty_o), 32'd1);
    chk("arst_ovf", 32'(ovf_o), 32'd0);
    chk("arst_udf", 32'(udf_o), 32'd0);
    chk("arst_to", 32'(timeout_o), 32'd0);
    step();
    rstn_i = 1'b1;
    trig_level_i = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
